// File: rtl/verdict_recorder.sv
// Capture stage for RTLola monitor verdicts: timestamps active output cycles into a FWFT FIFO.
// Optional duplicate suppression is enabled by defining VERDICT_RECORDER_DEDUP_EN.
module verdict_recorder #(
    parameter int NUM_OUT = 3,
    parameter int DATA_W  = 64,
    parameter int TS_W    = 32,
    parameter int DEPTH   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NUM_OUT*DATA_W-1:0] out_data,
    input  logic [NUM_OUT-1:0]        out_aktv,
    output logic                      rec_valid,
    input  logic                      rec_ready,
    output logic [TS_W-1:0]           rec_ts,
    output logic [NUM_OUT-1:0]        rec_aktv,
    output logic [NUM_OUT*DATA_W-1:0] rec_data,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic [15:0]               drop_cnt,
    output logic                      overflow
);

    localparam int AW    = $clog2(DEPTH);
    localparam int REC_W = TS_W + NUM_OUT + NUM_OUT * DATA_W;

    logic [REC_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      level;
    logic [TS_W-1:0]  ts;

    logic capture;
    logic dup;
    logic full;
    logic pop;
    logic push;
    logic drop;

`ifdef VERDICT_RECORDER_DEDUP_EN
    logic                      last_valid;
    logic [NUM_OUT-1:0]        last_aktv;
    logic [NUM_OUT*DATA_W-1:0] last_data;

    assign dup = last_valid && (out_aktv == last_aktv) && (out_data == last_data);

    // Only accepted records become the comparison reference; drops leave it untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_valid <= 1'b0;
            last_aktv  <= '0;
            last_data  <= '0;
        end else if (push) begin
            last_valid <= 1'b1;
            last_aktv  <= out_aktv;
            last_data  <= out_data;
        end
    end
`else
    assign dup = 1'b0;
`endif

    assign capture   = en && (|out_aktv) && !dup;
    assign rec_valid = (wr_ptr != rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = rec_valid && rec_ready;
    // A pop on the same edge frees the head slot, so a full FIFO can still accept.
    assign push      = capture && (!full || pop);
    assign drop      = capture && full && !pop;

    // NOTE: storage has no reset; validity is carried entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {ts, out_aktv, out_data};
    end

    assign {rec_ts, rec_aktv, rec_data} = mem[rd_ptr[AW-1:0]];
    assign fifo_level = level;

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            ts       <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (en)   ts     <= ts + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_verdict_recorder.sv
// Directed self-checking bench for verdict_recorder (default parameters).
module tb_verdict_recorder;

    logic         clk;
    logic         rst;
    logic         en;
    logic [191:0] out_data;
    logic [2:0]   out_aktv;
    logic         rec_valid;
    logic         rec_ready;
    logic [31:0]  rec_ts;
    logic [2:0]   rec_aktv;
    logic [191:0] rec_data;
    logic [4:0]   fifo_level;
    logic [15:0]  drop_cnt;
    logic         overflow;

    int          n_vec;
    int          n_bad;
    int unsigned ts_m;
    int unsigned push_ts;
    int unsigned t0;

    verdict_recorder dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .out_data   (out_data),
        .out_aktv   (out_aktv),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec_ts     (rec_ts),
        .rec_aktv   (rec_aktv),
        .rec_data   (rec_data),
        .fifo_level (fifo_level),
        .drop_cnt   (drop_cnt),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge; the model timestamp advances whenever en was high at that edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst && en) ts_m++;
    endtask

    task automatic pulse_reset();
        rst  = 1'b0;
        ts_m = 0;
        #1;
        rst  = 1'b1;
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        ts_m      = 0;
        rst       = 1'b0;
        en        = 1'b0;
        out_data  = '0;
        out_aktv  = '0;
        rec_ready = 1'b0;

        // Reset held, then idle with enable high.
        tick();
        tick();
        check("rst_valid", rec_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b1;
        en  = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("idle_valid", rec_valid, 0);
        check("idle_level", fifo_level, 0);
        check("idle_drop", drop_cnt, 0);

        // Single capture at ts=5.
        out_aktv = 3'b101;
        out_data = {-64'sd3, 64'sd9, 64'sd7};
        tick();
        out_aktv = '0;
        check("cap_valid", rec_valid, 1);
        check("cap_ts", rec_ts, 5);
        check("cap_aktv", rec_aktv, 3'b101);
        check("cap_d0", rec_data[63:0], 64'd7);
        check("cap_d1", rec_data[127:64], 64'd9);
        check("cap_d2", rec_data[191:128], -64'sd3);
        check("cap_level", fifo_level, 1);
        rec_ready = 1'b1;
        tick();
        rec_ready = 1'b0;
        check("pop_valid", rec_valid, 0);
        check("pop_level", fifo_level, 0);

        // Overflow: 20 captures into a 16-deep FIFO with the reader stalled.
        pulse_reset();
        check("rst2_level", fifo_level, 0);
        for (int i = 0; i < 20; i++) begin
            out_aktv = 3'b001;
            out_data = {128'd0, 64'(i)};
            tick();
        end
        out_aktv = '0;
        check("ovf_level", fifo_level, 16);
        check("ovf_drop", drop_cnt, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_head_ts", rec_ts, 0);
        tick();
        check("ovf_stall_ts", rec_ts, 0);

        // Full with simultaneous push and pop.
        rec_ready = 1'b1;
        out_aktv  = 3'b010;
        out_data  = {64'd0, 64'd100, 64'd0};
        push_ts   = ts_m;
        tick();
        out_aktv  = '0;
        check("pp_level", fifo_level, 16);
        check("pp_drop", drop_cnt, 4);
        check("pp_head_ts", rec_ts, 1);

        // Drain: ts 1..15 then the record pushed on the full edge.
        for (int i = 1; i <= 16; i++) begin
            check("drain_valid", rec_valid, 1);
            check("drain_ts", rec_ts, (i < 16) ? 64'(i) : 64'(push_ts));
            tick();
        end
        rec_ready = 1'b0;
        check("drain_empty", rec_valid, 0);
        check("drain_level", fifo_level, 0);

        // Enable low: no capture and timestamp frozen.
        en       = 1'b0;
        out_aktv = 3'b111;
        t0       = ts_m;
        for (int i = 0; i < 3; i++) tick();
        check("en0_level", fifo_level, 0);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            out_data = {128'd0, 64'(200 + i)};
            tick();
        end
        out_aktv = '0;
        check("en1_level", fifo_level, 4);
        check("en1_ts", rec_ts, t0);

        // Asynchronous reset mid-operation, observed without a clock edge.
        @(negedge clk);
        rst  = 1'b0;
        ts_m = 0;
        #1;
        check("arst_valid", rec_valid, 0);
        check("arst_level", fifo_level, 0);
        check("arst_drop", drop_cnt, 0);
        check("arst_ovf", overflow, 0);
        tick();
        rst = 1'b1;

        // Three identical captures then a changed one.
        t0 = ts_m;
        out_aktv = 3'b010;
        out_data = {64'd0, 64'd42, 64'd0};
        for (int i = 0; i < 3; i++) tick();
        out_data = {64'd0, 64'd43, 64'd0};
        tick();
        out_aktv = '0;
`ifdef VERDICT_RECORDER_DEDUP_EN
        check("dd_level", fifo_level, 2);
        check("dd_ts0", rec_ts, t0);
        rec_ready = 1'b1;
        tick();
        rec_ready = 1'b0;
        check("dd_ts1", rec_ts, t0 + 3);
        check("dd_data1", rec_data[127:64], 64'd43);
`else
        check("nd_level", fifo_level, 4);
        check("nd_ts0", rec_ts, t0);
        rec_ready = 1'b1;
        tick();
        rec_ready = 1'b0;
        check("nd_ts1", rec_ts, t0 + 1);
        check("nd_data1", rec_data[127:64], 64'd42);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
